// File: rtl/izh_update_scheduler.sv
// rtl/izh_update_scheduler.sv - time-multiplexed Izhikevich neuron update scheduler
// One shared dv/dw datapath walks every neuron through LOAD, CALC and WRITE.
module izh_update_scheduler #(
    parameter int N           = 16,
    parameter int Q           = 6,
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = $clog2(NUM_NEURONS),
    parameter logic [N-1:0] V_TH  = 16'h0780,
    parameter logic [N-1:0] V_RST = 16'hEFC0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N-1:0]           a,
    input  logic [N-1:0]           b,
    input  logic [N-1:0]           c,
    input  logic [N-1:0]           d,
    input  logic [N-1:0]           step,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       i_idx,
    input  logic [N-1:0]           i_data,
    output logic                   spike_valid,
    output logic [IDX_W-1:0]       spike_idx,
    output logic [NUM_NEURONS-1:0] spikes,
    input  logic                   init_we,
    input  logic [IDX_W-1:0]       init_idx,
    input  logic [N-1:0]           init_v,
    input  logic [N-1:0]           init_w,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [N-1:0]           rd_v,
    output logic [N-1:0]           rd_w
);
    localparam logic [N-1:0] K_P04  = N'(2);
    localparam logic [N-1:0] K_5    = N'(5 * (1 << Q));
    localparam logic [N-1:0] K_140  = N'(140 * (1 << Q));

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_FIN} state_t;
    state_t state, state_nx;

    logic [N-1:0] v_mem [NUM_NEURONS];
    logic [N-1:0] w_mem [NUM_NEURONS];
    logic [N-1:0] a_r, b_r, c_r, d_r, step_r;
    logic [N-1:0] v_r, w_r, i_r, dv_r, dw_r;
    logic [N-1:0] dv_c, dw_c, sum_c, bv_c;
    logic [IDX_W-1:0] idx;
    logic fire, last;

    // Fixed-point product: full-width signed multiply, then drop Q fraction bits.
    function automatic logic [N-1:0] mult(input logic [N-1:0] x, input logic [N-1:0] y);
        logic signed [2*N-1:0] xe, ye, p;
        xe = (2*N)'($signed(x));
        ye = (2*N)'($signed(y));
        p  = xe * ye;
        return N'(p >>> Q);
    endfunction

    function automatic logic [N-1:0] add(input logic [N-1:0] x, input logic [N-1:0] y);
        return x + y;
    endfunction

    function automatic logic [N-1:0] negator(input logic [N-1:0] x);
        return ~x + N'(1);
    endfunction

    always_comb begin
        sum_c = '0;
        bv_c  = '0;
        dv_c  = '0;
        dw_c  = '0;
        sum_c = add(add(add(mult(mult(v_r, v_r), K_P04), mult(v_r, K_5)), K_140),
                    add(negator(w_r), i_r));
        dv_c  = mult(sum_c, step_r);
        bv_c  = mult(b_r, v_r);
        dw_c  = mult(mult(a_r, add(bv_c, negator(w_r))), step_r);
    end

    assign fire  = ($signed(v_r) >= $signed(V_TH));
    assign last  = (idx == IDX_W'(NUM_NEURONS - 1));
    assign busy  = (state != S_IDLE);
    assign i_idx = idx;
    assign rd_v  = v_mem[rd_idx];
    assign rd_w  = w_mem[rd_idx];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_CALC;
            S_CALC:  state_nx = S_WRITE;
            S_WRITE: state_nx = last ? S_FIN : S_LOAD;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_mem[k] <= V_RST;
                w_mem[k] <= '0;
            end
            {a_r, b_r, c_r, d_r, step_r} <= '0;
            {v_r, w_r, i_r, dv_r, dw_r}  <= '0;
            idx         <= '0;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            spikes      <= '0;
        end else begin
            done        <= 1'b0;
            spike_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // start has priority: a coincident init write is dropped.
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        c_r    <= c;
                        d_r    <= d;
                        step_r <= step;
                        spikes <= '0;
                        idx    <= '0;
                    end else if (init_we) begin
                        v_mem[init_idx] <= init_v;
                        w_mem[init_idx] <= init_w;
                    end
                end
                S_LOAD: begin
                    v_r <= v_mem[idx];
                    w_r <= w_mem[idx];
                    i_r <= i_data;
                end
                S_CALC: begin
                    dv_r <= dv_c;
                    dw_r <= dw_c;
                end
                S_WRITE: begin
                    if (fire) begin
                        v_mem[idx]  <= c_r;
                        w_mem[idx]  <= add(w_r, d_r);
                        spike_valid <= 1'b1;
                        spike_idx   <= idx;
                        spikes[idx] <= 1'b1;
                    end else begin
                        v_mem[idx] <= add(v_r, dv_r);
                        w_mem[idx] <= add(w_r, dw_r);
                    end
                    if (!last) idx <= idx + 1'b1;
                end
                S_FIN: done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_izh_update_scheduler.sv
// tb/tb_izh_update_scheduler.sv - directed bench with spike scoreboard for izh_update_scheduler
module tb_izh_update_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0, c = '0, d = '0, step = '0;
    logic        busy, done;
    logic [2:0]  i_idx;
    logic [15:0] i_data;
    logic        spike_valid;
    logic [2:0]  spike_idx;
    logic [7:0]  spikes;
    logic        init_we = 1'b0;
    logic [2:0]  init_idx = '0;
    logic [15:0] init_v = '0, init_w = '0;
    logic [2:0]  rd_idx = '0;
    logic [15:0] rd_v, rd_w;
    logic [15:0] i_bump = '0;

    always #5 clk = ~clk;

    assign i_data = (i_idx == 3'd5) ? i_bump : 16'h0000;

    izh_update_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .c(c), .d(d), .step(step),
        .busy(busy), .done(done), .i_idx(i_idx), .i_data(i_data),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .spikes(spikes),
        .init_we(init_we), .init_idx(init_idx), .init_v(init_v), .init_w(init_w),
        .rd_idx(rd_idx), .rd_v(rd_v), .rd_w(rd_w)
    );

    typedef struct {int idx; int cyc;} exp_t;
    exp_t sbq[$];
    exp_t e;
    int total = 0, passed = 0, fails = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = -1;
    logic busy_at_done = 1'b1;
    int c0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && spike_valid) begin
            if (sbq.size() == 0) begin
                chk("spike_extra_queue", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("spike_idx", 32'(spike_idx), 32'(e.idx));
                chk("spike_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    end

    task automatic chk_state(input string tag, input int k, input logic [15:0] ev, input logic [15:0] ew);
        rd_idx = 3'(k);
        #1;
        chk($sformatf("%s_v%0d", tag, k), 32'(rd_v), 32'(ev));
        chk($sformatf("%s_w%0d", tag, k), 32'(rd_w), 32'(ew));
    endtask

    task automatic write_neuron(input int k, input logic [15:0] v, input logic [15:0] w);
        @(negedge clk);
        init_we = 1'b1; init_idx = 3'(k); init_v = v; init_w = w;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic kick(input logic [7:0] mask);
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++)
            if (mask[k]) sbq.push_back('{idx: k, cyc: c0 + 3 * k + 3});
    endtask

    task automatic run_sweep(input string tag, input logic [7:0] mask, input bit disturb);
        kick(mask);
        if (disturb) begin
            repeat (5) @(negedge clk);
            start = 1'b1; init_we = 1'b1; init_idx = 3'd3;
            init_v = 16'h1234; init_w = 16'h1234;
            @(negedge clk);
            start = 1'b0; init_we = 1'b0;
        end
        for (int i = 0; i < 60 && done_cnt == 0; i++) @(negedge clk);
        chk({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_latency"}, 32'(done_cyc - c0), 32'd25);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        repeat (30) @(negedge clk);
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_sb_drained"}, 32'(sbq.size()), 32'd0);
        chk({tag, "_spikes"}, 32'(spikes), 32'(mask));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Reset state
        for (int k = 0; k < 8; k++) chk_state("rst", k, 16'hEFC0, 16'h0000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_spikes", 32'(spikes), 32'd0);
        chk("rst_i_idx", 32'(i_idx), 32'd0);

        // Single neuron above threshold with step=0
        write_neuron(2, 16'h0780, 16'h0040);
        a = 16'h0000; b = 16'h0000; c = 16'hEFC0; d = 16'h0200; step = 16'h0000;
        run_sweep("one_spike", 8'h04, 1'b0);
        for (int k = 0; k < 8; k++)
            chk_state("one_spike", k, 16'hEFC0, (k == 2) ? 16'h0240 : 16'h0000);

        // Integration from zero: v = 140 (+ i for neuron 5)
        for (int k = 0; k < 8; k++) write_neuron(k, 16'h0000, 16'h0000);
        step = 16'h0040; i_bump = 16'h0040;
        run_sweep("integrate", 8'h00, 1'b0);
        for (int k = 0; k < 8; k++)
            chk_state("integrate", k, (k == 5) ? 16'h2340 : 16'h2300, 16'h0000);

        // Every neuron now above threshold
        run_sweep("all_fire", 8'hFF, 1'b0);
        for (int k = 0; k < 8; k++) chk_state("all_fire", k, 16'hEFC0, 16'h0200);

        // start and init_we while busy are ignored
        step = 16'h0000; i_bump = 16'h0000;
        run_sweep("disturb", 8'h00, 1'b1);
        chk_state("disturb", 3, 16'hEFC0, 16'h0200);

        // Reset mid-sweep
        write_neuron(2, 16'h0800, 16'h0000);
        kick(8'h04);
        while (cyc < c0 + 10) @(negedge clk);
        chk("pre_rst_spikes", 32'(spikes), 32'h04);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_spike_valid", 32'(spike_valid), 32'd0);
        chk("abort_spike_idx", 32'(spike_idx), 32'd0);
        chk("abort_spikes", 32'(spikes), 32'd0);
        chk("abort_i_idx", 32'(i_idx), 32'd0);
        for (int k = 0; k < 8; k++) chk_state("abort", k, 16'hEFC0, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_sb_drained", 32'(sbq.size()), 32'd0);

        // Normal sweep after the abort
        for (int k = 0; k < 8; k++) write_neuron(k, 16'h0000, 16'h0000);
        a = 16'h0000; b = 16'h0000; step = 16'h0040;
        run_sweep("post_rst", 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) chk_state("post_rst", k, 16'h2300, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/izh_update_scheduler.md
Name: izh_update_scheduler

Overview:
- Time-multiplexed Izhikevich neuron-update controller: owns v/w state for NUM_NEURONS neurons and runs one sweep per `start` pulse.
- Shares a single calc_dv instance and a single dw datapath across all neurons, sequencing them one neuron at a time.
- Sits between the network timestep controller (start/done) and the spike router (spike_valid/spike_idx).
- All arithmetic is signed N-bit fixed point with Q fractional bits, using the codebase mult/add/negator modules.

Parameters:
- N, 16, data width.
- Q, 6, fractional bits.
- NUM_NEURONS, 8, neurons held in the state arrays.
- IDX_W, $clog2(NUM_NEURONS), neuron index width.
- V_TH, 16'h0780, spike threshold (30.0).
- V_RST, 16'hEFC0, reset value of every v entry (-65.0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  sweep request pulse; sampled only in IDLE.
- a, b, c, d  in  N each  Izhikevich parameters; latched on an accepted start.
- step  in  N  integration step; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last neuron is written.
- i_idx  out  IDX_W  neuron whose input current is requested.
- i_data  in  N  input current for i_idx; combinational, valid in the same cycle.
- spike_valid  out  1  one-cycle pulse when a neuron fires.
- spike_idx  out  IDX_W  index of the firing neuron; valid with spike_valid.
- spikes  out  NUM_NEURONS  spike bits from the current/most recent sweep.
- init_we  in  1  state write strobe; honoured only in IDLE, ignored when busy.
- init_idx  in  IDX_W  index for the state write.
- init_v, init_w  in  N each  values to write.
- rd_idx  in  IDX_W  combinational read index.
- rd_v, rd_w  out  N each  state of neuron rd_idx.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; busy=0, done=0, spike_valid=0, spike_idx=0, spikes=0, i_idx=0.
  - All v entries = V_RST, all w entries = 0; latched parameters = 0.
  - Asserting reset mid-sweep aborts the sweep; no done is produced.
- IDLE:
  - start=1 latches a, b, c, d, step, clears spikes, sets idx=0, and moves to LOAD.
  - init_we=1 with start=0 writes v[init_idx], w[init_idx] at the edge.
  - If start and init_we are high in the same cycle, start wins and the write is dropped.
- LOAD (1 cycle):
  - i_idx=idx.
  - Registers operands: v_r=v[idx], w_r=w[idx], i_r=i_data.
- CALC (1 cycle):
  - Registers dv = calc_dv(v_r, w_r, i_r, step) = (0.04*v*v + 5*v + 140 - w + i)*step, with the 0.04 constant at 16'h0002.
  - Registers dw = a*(b*v_r - w_r)*step, via mult/add/negator.
- WRITE (1 cycle):
  - If v_r >= V_TH (signed compare, old v): v[idx]=c, w[idx]=w_r+d, spike_valid=1, spike_idx=idx, spikes[idx]=1.
  - Otherwise: v[idx]=v_r+dv and w[idx]=w_r+dw, using the add module, with no saturation beyond add semantics.
  - If idx==NUM_NEURONS-1: go to IDLE and pulse done in the next cycle (busy drops with done). Otherwise idx+1 and go to LOAD.
- Timing:
  - Exactly 3 cycles per neuron.
  - done is asserted 3*NUM_NEURONS+1 cycles after the start edge.
- start while busy: ignored; no queueing.
- Read port: rd_v/rd_w are always combinational from the arrays, including mid-sweep.
- spikes: holds its value after done until the next accepted start.

Test Plan:
- Reset, then read all indices -> rd_v=16'hEFC0, rd_w=0; busy=done=spikes=0.
- Init neuron 2 with v=16'h0780, w=16'h0040; step=0, c=16'hEFC0, d=16'h0200; start -> one spike_valid with spike_idx=2; rd_v[2]=16'hEFC0, rd_w[2]=16'h0240; spikes=8'b00000100.
- Init all neurons v=0, w=0; i_data=0, step=16'h0040, a=b=0 -> done 25 cycles after start; every v=16'h2300 (140.0), w=0; no spikes.
- Second sweep after the previous scenario (v=140.0 >= V_TH) -> 8 spike pulses in index order, 3 cycles apart; spikes=8'hFF; all v=c, w=d.
- start and init_we pulsed mid-sweep -> no restart and no state write; done occurs exactly once, at the original cycle.
- rst_n low at cycle 10 of a sweep -> all outputs and arrays at reset values immediately; no done; a new start then runs a normal sweep.
